// File: rtl/mse_bus_pkg.sv
// mse_bus_pkg: shared types and constants for the MSE bus initiator.
// Holds the FSM state enum, default bus timing, and the byte returned
// by a read that times out (only used when MSE_BUS_TIMEOUT_EN is defined).
package mse_bus_pkg;

  // Transfer phases on the external bus
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } mse_state_e;

  // Default timing, in csi_MCLK_clk cycles
  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_STROBE_CYC  = 4;
  localparam int DEF_HOLD_CYC    = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Byte handed back to the Avalon master when a read is abandoned
  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  // Terminal value of a 4-bit phase counter that must span 'cyc' cycles
  function automatic logic [3:0] phase_last(input int cyc);
    return 4'(cyc - 1);
  endfunction

endpackage

// File: rtl/mse_sync2.sv
// mse_sync2: generic two-flop synchronizer with asynchronous active-low reset.
// Each bit is synchronized independently; use only for level signals where
// bit-to-bit coherency does not matter.
module mse_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_q;
    logic sync_q;

    // First stage may go metastable; second stage gives it a cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= d[gi];
        sync_q <= meta_q;
      end
    end

    assign q[gi] = sync_q;
  end

endmodule

// File: rtl/mse_bus_initiator.sv
// mse_bus_initiator: Avalon-MM slave that runs single byte transfers as
// timed SETUP / STROBE / HOLD cycles on the MSE 8-bit parallel bus.
// Optional feature macro: MSE_BUS_TIMEOUT_EN -- when defined, a WAIT-extended
// strobe is abandoned after TIMEOUT_CYC extra cycles and coe_S1_TIMEOUT is set.
// All bus strobes and enables are registered so the pins never glitch on
// state-decode transitions; they are computed from the next state so their
// timing still lines up with the state they belong to.
module mse_bus_initiator
  import mse_bus_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [7:0]  avs_S1_address,
  input  logic [31:0] avs_S1_writedata,
  input  logic [3:0]  avs_S1_byteenable,
  input  logic        avs_S1_write,
  input  logic        avs_S1_read,
  output logic [31:0] avs_S1_readdata,
  output logic        avs_S1_waitrequest,
  output logic [7:0]  coe_S1_ADDR,
  inout  wire  [7:0]  coe_S1_DATA,
  output logic        coe_S1_RD,
  output logic        coe_S1_WR,
  input  logic        coe_S1_WAIT,
  output logic        coe_S1_TIMEOUT
);

  localparam logic [3:0]  SETUP_LAST  = phase_last(SETUP_CYC);
  localparam logic [3:0]  STROBE_LAST = phase_last(STROBE_CYC);
  localparam logic [3:0]  HOLD_LAST   = phase_last(HOLD_CYC);
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYC);

  // FSM and datapath state
  mse_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;          // phase cycle counter
  logic [7:0]  addr_q, addr_d;        // latched bus address
  logic [7:0]  wbyte_q, wbyte_d;      // latched write byte
  logic        is_wr_q, is_wr_d;      // direction of the current transfer
  logic [7:0]  rdata_q, rdata_d;      // captured read byte

  // Registered pin controls
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        oe_q, oe_d;
  logic        waitreq_q, waitreq_d;

  logic        wait_s;
  logic        strobe_min_done;
  logic [7:0]  bus_in;

`ifdef MSE_BUS_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;    // WAIT-extended strobe cycles so far
  logic        timeout_q, timeout_d;  // sticky timeout flag
`endif

  // Unused Avalon lanes are deliberately dropped: only byte lane 0 is carried
  logic unused_inputs;
`ifdef MSE_BUS_TIMEOUT_EN
  assign unused_inputs = ^{avs_S1_writedata[31:8], avs_S1_byteenable[3:1]};
`else
  assign unused_inputs = ^{avs_S1_writedata[31:8], avs_S1_byteenable[3:1], TIMEOUT_VAL};
`endif

  // WAIT comes from the far FPGA with no clock relationship to ours
  mse_sync2 #(
    .WIDTH (1)
  ) u_wait_sync (
    .clk   (csi_MCLK_clk),
    .rst_n (rsi_MRST_reset_n),
    .d     (coe_S1_WAIT),
    .q     (wait_s)
  );

  assign bus_in          = coe_S1_DATA;
  assign strobe_min_done = (cnt_q == STROBE_LAST);

  // State register: all flops, reset straight back to a released, idle bus
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wbyte_q   <= '0;
      is_wr_q   <= 1'b0;
      rdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      oe_q      <= 1'b0;
      waitreq_q <= 1'b1;
`ifdef MSE_BUS_TIMEOUT_EN
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wbyte_q   <= wbyte_d;
      is_wr_q   <= is_wr_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      oe_q      <= oe_d;
      waitreq_q <= waitreq_d;
`ifdef MSE_BUS_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state logic: phase sequencing, request latching and read capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wbyte_d  = wbyte_q;
    is_wr_d  = is_wr_q;
    rdata_d  = rdata_q;
`ifdef MSE_BUS_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (avs_S1_write || avs_S1_read) begin
          // A simultaneous read is dropped: the write takes the bus
          addr_d  = avs_S1_address;
          wbyte_d = avs_S1_writedata[7:0];
          is_wr_d = avs_S1_write;
          cnt_d   = '0;
`ifdef MSE_BUS_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          // A write with lane 0 disabled carries nothing; just acknowledge it
          if (avs_S1_write && !avs_S1_byteenable[0]) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
`ifdef MSE_BUS_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_STROBE: begin
        if (!strobe_min_done) begin
          cnt_d = cnt_q + 4'd1;
        end else if (!wait_s) begin
          // Final strobe edge: the responder's byte is sampled here
          state_d = ST_HOLD;
          cnt_d   = '0;
          if (!is_wr_q) begin
            rdata_d = bus_in;
          end
        end
`ifdef MSE_BUS_TIMEOUT_EN
        else if (to_cnt_q == TIMEOUT_VAL) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          timeout_d = 1'b1;
          if (!is_wr_q) begin
            rdata_d = TIMEOUT_RDATA;
          end
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so registered pins match the phase
  always_comb begin
    rd_d      = (state_d == ST_STROBE) && !is_wr_d;
    wr_d      = (state_d == ST_STROBE) &&  is_wr_d;
    oe_d      = is_wr_d && ((state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                            (state_d == ST_HOLD));
    waitreq_d = (state_d != ST_DONE);
  end

  assign avs_S1_readdata    = {24'h0, rdata_q};
  assign avs_S1_waitrequest = waitreq_q;
  assign coe_S1_ADDR        = addr_q;
  assign coe_S1_DATA        = oe_q ? wbyte_q : 8'bz;
  assign coe_S1_RD          = rd_q;
  assign coe_S1_WR          = wr_q;
`ifdef MSE_BUS_TIMEOUT_EN
  assign coe_S1_TIMEOUT     = timeout_q;
`else
  assign coe_S1_TIMEOUT     = 1'b0;
`endif

endmodule

// File: tb/tb_mse_bus_initiator.sv
// tb_mse_bus_initiator: directed bench for mse_bus_initiator.
// A per-transaction model derives the expected pin waveform from the bus
// timing rules (setup, minimum strobe stretched by the synchronized WAIT,
// hold, one-cycle done) and a compare process checks it every cycle.
module tb_mse_bus_initiator;

  localparam int SETUP_CYC   = 2;
  localparam int STROBE_CYC  = 4;
  localparam int HOLD_CYC    = 2;
  localparam int TIMEOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  avs_address = '0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  bus_addr;
  wire  [7:0]  bus_data;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_wait = 1'b0;
  logic        bus_timeout;

  // Responder / background driver on the data bus
  logic        tb_drv_en = 1'b1;
  logic [7:0]  tb_drv_val = 8'h00;
  assign bus_data = tb_drv_en ? tb_drv_val : 8'bz;

  always #5 clk = ~clk;

  mse_bus_initiator #(
    .SETUP_CYC   (SETUP_CYC),
    .STROBE_CYC  (STROBE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .csi_MCLK_clk       (clk),
    .rsi_MRST_reset_n   (rst_n),
    .avs_S1_address     (avs_address),
    .avs_S1_writedata   (avs_writedata),
    .avs_S1_byteenable  (avs_byteenable),
    .avs_S1_write       (avs_write),
    .avs_S1_read        (avs_read),
    .avs_S1_readdata    (avs_readdata),
    .avs_S1_waitrequest (avs_waitrequest),
    .coe_S1_ADDR        (bus_addr),
    .coe_S1_DATA        (bus_data),
    .coe_S1_RD          (bus_rd),
    .coe_S1_WR          (bus_wr),
    .coe_S1_WAIT        (bus_wait),
    .coe_S1_TIMEOUT     (bus_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected waveform of the current transaction, indexed by cycle
  logic [7:0]  exp_addr [64];
  logic [7:0]  exp_bus  [64];
  bit          exp_rd   [64];
  bit          exp_wr   [64];
  bit          exp_oe   [64];
  bit          exp_wreq [64];
  bit          exp_to   [64];
  logic [31:0] exp_rdata;
  bit          exp_is_read;
  int          done_c;
  int          cyc;
  bit          chk_en = 1'b0;

  // Model memory carried across transactions
  logic [7:0]  prev_addr = 8'h00;
  bit          to_model  = 1'b0;

  // Observations for the hand-computed literal checks
  int          obs_rd, obs_wr, obs_done;
  logic [31:0] obs_rdata;
  int          txn_no = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  function automatic bit wait_s_at(input int c, input int ws, input int wl);
    return (wl > 0) && (c - 2 >= ws) && (c - 2 < ws + wl);
  endfunction

  // Compare process: DUT pins against the model on every transaction cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ADDR",        {24'h0, bus_addr},  {24'h0, exp_addr[cyc]});
      chk("DATA",        {24'h0, bus_data},  {24'h0, exp_bus[cyc]});
      chk("RD",          {31'h0, bus_rd},    {31'h0, exp_rd[cyc]});
      chk("WR",          {31'h0, bus_wr},    {31'h0, exp_wr[cyc]});
      chk("WAITREQUEST", {31'h0, avs_waitrequest}, {31'h0, exp_wreq[cyc]});
      chk("TIMEOUT",     {31'h0, bus_timeout},     {31'h0, exp_to[cyc]});
      if (cyc == done_c && exp_is_read)
        chk("READDATA", avs_readdata, exp_rdata);
      if (bus_rd) obs_rd++;
      if (bus_wr) obs_wr++;
      if (!avs_waitrequest) begin
        obs_done  = cyc;
        obs_rdata = avs_readdata;
      end
    end
  end

  // One Avalon transfer; starts just after an edge with the DUT idle
  task automatic run_txn(input bit rd, input bit wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [7:0] resp, input int ws, input int wl);
    bit   nocyc;
    bit   tmo;
    int   s0, e;
    logic [7:0] bg;
    nocyc = wr && !be[0];
    tmo   = 1'b0;
    s0    = 1 + SETUP_CYC;
    e     = s0 - 1;
    bg    = wr ? 8'h00 : resp;
    if (nocyc) begin
      done_c = 1;
    end else begin
      e = s0 + STROBE_CYC - 1;
      while (wait_s_at(e, ws, wl)) begin
`ifdef MSE_BUS_TIMEOUT_EN
        if (e - (s0 + STROBE_CYC - 1) == TIMEOUT_CYC) begin
          tmo = 1'b1;
          break;
        end
`endif
        e++;
      end
      done_c = e + HOLD_CYC + 1;
    end
    for (int c = 0; c <= done_c; c++) begin
      exp_addr[c] = (c == 0) ? prev_addr : a;
      exp_rd[c]   = !nocyc && !wr && c >= s0 && c <= e;
      exp_wr[c]   = !nocyc &&  wr && c >= s0 && c <= e;
      exp_oe[c]   = !nocyc &&  wr && c >= 1  && c <= e + HOLD_CYC;
      exp_bus[c]  = exp_oe[c] ? wd[7:0] : bg;
      exp_wreq[c] = (c != done_c);
      exp_to[c]   = (c == 0) ? to_model : (tmo && c > e);
    end
    exp_is_read = !wr;
    exp_rdata   = tmo ? 32'h0000_00FF : {24'h0, resp};

    obs_rd = 0; obs_wr = 0; obs_done = -1; obs_rdata = '0;
    avs_address = a; avs_writedata = wd; avs_byteenable = be;
    avs_read = rd; avs_write = wr;
    tb_drv_val = bg;
    chk_en = 1'b1;
    for (int c = 0; c <= done_c; c++) begin
      cyc = c;
      bus_wait  = (wl > 0) && (c >= ws) && (c < ws + wl);
      tb_drv_en = !exp_oe[c];
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    avs_read = 1'b0; avs_write = 1'b0; bus_wait = 1'b0;
    tb_drv_en = 1'b1; tb_drv_val = 8'h00;
    prev_addr = a;
    to_model  = tmo;
    txn_no++;
    $display("txn %0d %s addr=%02h done_cycle=%0d rd_cycles=%0d wr_cycles=%0d readdata=%08h",
             txn_no, wr ? "write" : "read ", a, obs_done, obs_rd, obs_wr, obs_rdata);
  endtask

  initial begin
    cyc = 0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("RST_ADDR",   {24'h0, bus_addr}, 32'h0);
    chk("RST_RD",     {31'h0, bus_rd},   32'h0);
    chk("RST_WR",     {31'h0, bus_wr},   32'h0);
    chk("RST_WREQ",   {31'h0, avs_waitrequest}, 32'h1);
    chk("RST_RDATA",  avs_readdata,      32'h0);
    chk("RST_TO",     {31'h0, bus_timeout}, 32'h0);
    chk("RST_DATA",   {24'h0, bus_data}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain write
    run_txn(1'b0, 1'b1, 8'h3C, 32'h0000_00A5, 4'b0001, 8'h00, 0, 0);
    chk("W1_WR_CYCLES", obs_wr, 4);
    chk("W1_DONE_CYC",  obs_done, 9);

    // Plain read; latched write byte A5 differs from responder byte
    run_txn(1'b1, 1'b0, 8'h10, 32'h0000_00A5, 4'b0001, 8'h5A, 0, 0);
    chk("R1_RD_CYCLES", obs_rd, 4);
    chk("R1_DONE_CYC",  obs_done, 9);
    chk("R1_READDATA",  obs_rdata, 32'h0000_005A);

    // Read stretched by WAIT high for cycles 2..11
    run_txn(1'b1, 1'b0, 8'h20, 32'h0000_00C3, 4'b0001, 8'h96, 2, 10);
    chk("R2_RD_CYCLES", obs_rd, 12);
    chk("R2_DONE_CYC",  obs_done, 17);
    chk("R2_READDATA",  obs_rdata, 32'h0000_0096);

    // Read and write together: the write wins
    run_txn(1'b1, 1'b1, 8'h44, 32'h0000_00C3, 4'b0001, 8'h00, 0, 0);
    chk("RW_RD_CYCLES", obs_rd, 0);
    chk("RW_WR_CYCLES", obs_wr, 4);

    // Write with lane 0 disabled: no bus cycle
    run_txn(1'b0, 1'b1, 8'h55, 32'h0000_0011, 4'b0000, 8'h00, 0, 0);
    chk("BE0_WR_CYCLES", obs_wr, 0);
    chk("BE0_DONE_CYC",  obs_done, 1);

    // Reset during STROBE cycle 4 of a read
    avs_address = 8'h22; avs_writedata = 32'h0000_00A5; avs_byteenable = 4'b0001;
    avs_read = 1'b1; tb_drv_val = 8'h77; tb_drv_en = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("PRE_RST_RD", {31'h0, bus_rd}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("MID_RST_RD",   {31'h0, bus_rd}, 32'h0);
    chk("MID_RST_WR",   {31'h0, bus_wr}, 32'h0);
    chk("MID_RST_WREQ", {31'h0, avs_waitrequest}, 32'h1);
    chk("MID_RST_ADDR", {24'h0, bus_addr}, 32'h0);
    chk("MID_RST_DATA", {24'h0, bus_data}, 32'h0000_0077);
    avs_read = 1'b0; tb_drv_val = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_addr = 8'h00;
    to_model  = 1'b0;
    run_txn(1'b1, 1'b0, 8'h10, 32'h0000_0000, 4'b0001, 8'h69, 0, 0);
    chk("POST_RST_RDATA", obs_rdata, 32'h0000_0069);
    chk("POST_RST_DONE",  obs_done, 9);

`ifdef MSE_BUS_TIMEOUT_EN
    // WAIT stuck high: strobe abandoned after TIMEOUT_CYC extra cycles
    run_txn(1'b1, 1'b0, 8'h66, 32'h0000_00A5, 4'b0001, 8'h12, 2, 60);
    chk("TO_RD_CYCLES", obs_rd, 12);
    chk("TO_READDATA",  obs_rdata, 32'h0000_00FF);
    chk("TO_FLAG",      {31'h0, bus_timeout}, 32'h1);
    // Next accepted request clears the flag (model checks cycle 0 vs 1)
    run_txn(1'b0, 1'b1, 8'h77, 32'h0000_003E, 4'b0001, 8'h00, 0, 0);
    chk("TO_CLEARED",   {31'h0, bus_timeout}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
